game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Central game-flow controller for the dino game. It sequences the IDLE/RUN/PAUSE/HIT/OVER lifecycle and owns the frame-rate tick and the lives counter. It also drives the screen_ready/frame_ack handshake between the VGA frame pipeline and the CPU. It sits between the top level, the CPU wrapper, the VGA controller (collision_detected in; lives and game_over out) and the score counter (score_tick).

Parameters:
FRAME_DIV, 33333333, clk cycles per game frame (3 fps at 100 MHz); legal range ≥ 2.
INVULN_FRAMES, 4, frames of collision immunity after a hit; legal range ≥ 1.
START_LIVES, 3, lives loaded when a game starts; legal range 1..3.

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous, active-low reset
button_press  in  1  jump/start button, level
pause_switch  in  1  pause request, level
collision_detected  in  1  dino/obstacle overlap from the VGA controller, level
frame_ack  in  1  CPU done with current frame; single-cycle pulse or level
frame_tick  out  1  one-cycle pulse per game frame
screen_ready  out  1  frame available to the CPU
frame_overrun  out  1  sticky: a frame_tick occurred while screen_ready was still set
score_tick  out  1  one-cycle pulse, drives score counter clock enable
lives  out  2  remaining lives
game_over  out  1  high in OVER state
state  out  3  IDLE=0, RUN=1, PAUSED=2, HIT=3, OVER=4

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, lives=START_LIVES, frame counter=0, invuln counter=0, btn_q=0, col_q=0. All pulse outputs, screen_ready, frame_overrun and game_over are 0.
- Reset applies mid-game with the same values. It has priority over every event in the same cycle.
- Edge detect: btn_rise = button_press & ~btn_q; col_rise = collision_detected & ~col_q. btn_q and col_q are registered every cycle.
- Frame counter: counts 0..FRAME_DIV-1 in RUN and HIT only. It is held in PAUSED, and cleared in IDLE and OVER.
- frame_tick is asserted for one cycle on the edge where the counter wraps from FRAME_DIV-1 to 0. The first tick comes FRAME_DIV cycles after entering RUN.
- score_tick equals frame_tick. Score therefore advances in RUN and HIT, never in PAUSED, IDLE or OVER.
- screen_ready is set on frame_tick and cleared on the edge after frame_ack=1.
- If frame_tick and frame_ack occur in the same cycle, screen_ready stays 1 (the new frame wins).
- If frame_tick occurs while screen_ready=1 and frame_ack=0, frame_overrun is set. It is cleared only by reset.
- Transitions, evaluated at each clk edge:
  IDLE: on btn_rise → RUN, with lives=START_LIVES and the frame counter cleared.
  RUN: on col_rise → lives-1. If the old lives value was 1 → OVER; otherwise → HIT with invuln=INVULN_FRAMES. Else, if pause_switch=1 → PAUSED with ret=RUN.
  HIT: collisions are ignored. invuln decrements on each frame_tick; when invuln reaches 0 → RUN. If pause_switch=1 → PAUSED with ret=HIT, and invuln is frozen.
  PAUSED: when pause_switch=0 → ret. Counters and lives are frozen and col_rise is ignored. col_q keeps updating, so a collision level that persists across unpause does not produce an edge.
  OVER: game_over=1 and lives=0. On btn_rise → RUN, with lives=START_LIVES and the counter cleared. Pause is ignored.
- Simultaneous events: col_rise has priority over pause_switch in RUN. In HIT, the invuln-expiry transition to RUN has priority over pause in the same cycle; pause is then taken on the next cycle.
- lives never underflows below 0. A button press in RUN, HIT or PAUSED has no effect on this block.

Optional Feature:
SYNC_INPUTS_EN
- Defined: button_press, pause_switch and collision_detected each pass through a 2-flop synchronizer before edge detection and FSM use. All input-to-state latency grows by 2 cycles, and the synchronizer flops reset to 0.
- Undefined: inputs are used directly, as specified above.

Test Plan:
Bench configuration is FRAME_DIV=4, INVULN_FRAMES=2, START_LIVES=3.
- Reset then button pulse: state IDLE→RUN the cycle after the rise. frame_tick and score_tick pulse every 4 cycles. lives=3.
- No frame_ack for 2 ticks: screen_ready=1 after tick 1, frame_overrun=1 after tick 2. Pulse frame_ack → screen_ready=0 on the next edge; frame_overrun stays 1.
- col_rise in RUN: lives 3→2 and state=HIT. A second col_rise during HIT leaves lives=2. After 2 frame_ticks → RUN.
- Three separated collisions: lives 3→2→1→0, state=OVER, game_over=1, ticks stop. Then a button pulse → RUN with lives=3 and game_over=0.
- pause_switch=1 in HIT with invuln=1 and counter=2: PAUSED, no ticks for 20 cycles, counter holds 2. Release → HIT; a tick comes 2 cycles later, then RUN.
- reset=0 asserted in HIT: on the next edge state=IDLE, lives=3, screen_ready=0, frame_overrun=0.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE/RUN/PAUSED/HIT/OVER lifecycle, frame tick, lives, CPU frame handshake.
// Optional SYNC_INPUTS_EN adds 2-flop synchronizers on button_press, pause_switch and collision_detected.
module game_sequencer #(
  parameter int FRAME_DIV     = 33333333,
  parameter int INVULN_FRAMES = 4,
  parameter int START_LIVES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_press,
  input  logic       pause_switch,
  input  logic       collision_detected,
  input  logic       frame_ack,
  output logic       frame_tick,
  output logic       screen_ready,
  output logic       frame_overrun,
  output logic       score_tick,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int CW = $clog2(FRAME_DIV);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(FRAME_DIV - 1);
  localparam logic [IW-1:0] INV_INIT   = IW'(INVULN_FRAMES);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_HIT    = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  // Bit order: {collision, pause, button}
  logic [2:0] raw_in;
  logic [2:0] sync_in;
  assign raw_in = {collision_detected, pause_switch, button_press};

`ifdef SYNC_INPUTS_EN
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
      if (!reset) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], raw_in[gi]};
    end
    assign sync_in[gi] = sync_q[1];
  end
`else
  assign sync_in = raw_in;
`endif

  logic btn_in, pause_in, col_in;
  assign btn_in   = sync_in[0];
  assign pause_in = sync_in[1];
  assign col_in   = sync_in[2];

  state_t        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] invuln_q, invuln_d;
  logic          ret_hit_q, ret_hit_d;
  logic          btn_q, col_q;
  logic          tick_q, ready_q, ready_d, overrun_q, overrun_d;

  logic btn_rise, col_rise, counting, wrap;
  assign btn_rise = btn_in & ~btn_q;
  assign col_rise = col_in & ~col_q;
  assign counting = (state_q == S_RUN) || (state_q == S_HIT);
  assign wrap     = counting && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lives_q   <= LIVES_INIT;
      cnt_q     <= '0;
      invuln_q  <= '0;
      ret_hit_q <= 1'b0;
      btn_q     <= 1'b0;
      col_q     <= 1'b0;
      tick_q    <= 1'b0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      invuln_q  <= invuln_d;
      ret_hit_q <= ret_hit_d;
      btn_q     <= btn_in;
      col_q     <= col_in;
      tick_q    <= wrap;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    invuln_d  = invuln_q;
    ret_hit_d = ret_hit_q;

    // Counter runs in RUN/HIT, freezes in PAUSED, sits at zero otherwise.
    if (counting)                  cnt_d = wrap ? '0 : cnt_q + 1'b1;
    else if (state_q == S_PAUSED)  cnt_d = cnt_q;
    else                           cnt_d = '0;

    // A fresh frame always wins over a simultaneous acknowledge.
    ready_d   = wrap ? 1'b1 : (frame_ack ? 1'b0 : ready_q);
    overrun_d = overrun_q | (wrap & ready_q & ~frame_ack);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (btn_rise) begin
          state_d = S_RUN;
          lives_d = LIVES_INIT;
        end
      end
      S_RUN: begin
        if (col_rise) begin
          if (lives_q <= 2'd1) begin
            state_d = S_OVER;
            lives_d = 2'd0;
          end else begin
            state_d  = S_HIT;
            lives_d  = lives_q - 2'd1;
            invuln_d = INV_INIT;
          end
        end else if (pause_in) begin
          state_d   = S_PAUSED;
          ret_hit_d = 1'b0;
        end
      end
      S_HIT: begin
        // Expiry beats pause; a still-held pause is taken from RUN next cycle.
        if (wrap && invuln_q <= IW'(1)) begin
          state_d  = S_RUN;
          invuln_d = '0;
        end else begin
          if (wrap) invuln_d = invuln_q - 1'b1;
          if (pause_in) begin
            state_d   = S_PAUSED;
            ret_hit_d = 1'b1;
          end
        end
      end
      S_PAUSED: begin
        if (!pause_in) state_d = ret_hit_q ? S_HIT : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_tick    = tick_q;
  assign score_tick    = tick_q;
  assign screen_ready  = ready_q;
  assign frame_overrun = overrun_q;
  assign lives         = lives_q;
  assign game_over     = (state_q == S_OVER);
  assign state         = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (FRAME_DIV=4, INVULN_FRAMES=2, START_LIVES=3).
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_press, pause_switch, collision_detected, frame_ack;
  logic       frame_tick, screen_ready, frame_overrun, score_tick, game_over;
  logic [1:0] lives;
  logic [2:0] state;

  int tests  = 0;
  int failed = 0;

  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, PAUSED = 3'd2, HIT = 3'd3, OVER = 3'd4;

  game_sequencer #(.FRAME_DIV(4), .INVULN_FRAMES(2), .START_LIVES(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .button_press      (button_press),
    .pause_switch      (pause_switch),
    .collision_detected(collision_detected),
    .frame_ack         (frame_ack),
    .frame_tick        (frame_tick),
    .screen_ready      (screen_ready),
    .frame_overrun     (frame_overrun),
    .score_tick        (score_tick),
    .lives             (lives),
    .game_over         (game_over),
    .state             (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0; button_press = 1'b0; pause_switch = 1'b0;
    collision_detected = 1'b0; frame_ack = 1'b0;
    step(); step();
    chk("rst_state", state, IDLE);
    chk("rst_lives", lives, 3);
    chk("rst_tick", frame_tick, 0);
    chk("rst_score", score_tick, 0);
    chk("rst_ready", screen_ready, 0);
    chk("rst_overrun", frame_overrun, 0);
    chk("rst_gameover", game_over, 0);
    reset = 1'b1;
    step(); step();
    chk("idle_hold", state, IDLE);

    // Start: RUN on the edge that sees the rise
    button_press = 1'b1;
    step();
    chk("start_run", state, RUN);
    chk("start_lives", lives, 3);
    button_press = 1'b0;

    // Ticks every 4 cycles; no ack -> ready then overrun
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("tick", frame_tick, (i % 4 == 0) ? 1 : 0);
      chk("score", score_tick, (i % 4 == 0) ? 1 : 0);
      if (i == 4) begin
        chk("ready_t1", screen_ready, 1);
        chk("overrun_t1", frame_overrun, 0);
      end
    end
    chk("overrun_t2", frame_overrun, 1);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("ack_ready", screen_ready, 0);
    chk("ack_overrun", frame_overrun, 1);

    // First collision: lives 3->2, HIT
    collision_detected = 1'b1;
    step();
    chk("hit1_state", state, HIT);
    chk("hit1_lives", lives, 2);
    collision_detected = 1'b0;
    step();
    collision_detected = 1'b1;           // ignored in HIT
    step();
    chk("hit_ign_tick", frame_tick, 1);
    chk("hit_ign_lives", lives, 2);
    chk("hit_ign_state", state, HIT);
    chk("ready_again", screen_ready, 1);
    collision_detected = 1'b0;
    step(); step(); step();
    chk("hit_still", state, HIT);
    step();
    chk("hit_exp_tick", frame_tick, 1);
    chk("hit_exp_state", state, RUN);

    // Second collision: lives 2->1, then pause at invuln=1, counter=2
    collision_detected = 1'b1;
    step();
    chk("hit2_lives", lives, 1);
    chk("hit2_state", state, HIT);
    collision_detected = 1'b0;
    step(); step(); step();
    chk("hit2_tick", frame_tick, 1);
    step();
    pause_switch = 1'b1;
    step();
    chk("pause_enter", state, PAUSED);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("pause_tick", frame_tick, 0);
      chk("pause_state", state, PAUSED);
      if (i == 5) collision_detected = 1'b1;   // held across unpause: no edge
    end
    chk("pause_lives", lives, 1);
    pause_switch = 1'b0;
    step();
    chk("unpause_state", state, HIT);
    chk("unpause_tick", frame_tick, 0);
    step();
    chk("unpause_tick2", frame_tick, 0);
    step();
    chk("resume_tick", frame_tick, 1);
    chk("resume_state", state, RUN);
    step();
    chk("held_col_lives", lives, 1);
    chk("held_col_state", state, RUN);
    collision_detected = 1'b0;
    step();

    // Third collision: lives 1->0, OVER
    collision_detected = 1'b1;
    step();
    collision_detected = 1'b0;
    chk("over_state", state, OVER);
    chk("over_lives", lives, 0);
    chk("over_flag", game_over, 1);
    pause_switch = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("over_no_tick", frame_tick, 0);
    end
    chk("over_pause_ign", state, OVER);
    pause_switch = 1'b0;
    button_press = 1'b1;
    step();
    button_press = 1'b0;
    chk("restart_state", state, RUN);
    chk("restart_lives", lives, 3);
    chk("restart_gover", game_over, 0);

    // Collision and pause together: collision wins, pause taken next
    collision_detected = 1'b1;
    pause_switch = 1'b1;
    step();
    collision_detected = 1'b0;
    chk("colpri_state", state, HIT);
    chk("colpri_lives", lives, 2);
    step();
    chk("hit_pause", state, PAUSED);
    pause_switch = 1'b0;
    step();
    chk("hit_ret", state, HIT);
    chk("pre_rst_ready", screen_ready, 1);
    chk("pre_rst_overrun", frame_overrun, 1);

    // Mid-game reset from HIT
    reset = 1'b0;
    step();
    chk("midrst_state", state, IDLE);
    chk("midrst_lives", lives, 3);
    chk("midrst_ready", screen_ready, 0);
    chk("midrst_overrun", frame_overrun, 0);
    reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
